bch_encode_stream: RTL and testbench
====================================

Name: bch_encode_stream

Overview:
- Parametrised systematic binary BCH encoder. Successor to the bit-serial encoder.
- Accepts a K-bit message as WIDTH-bit beats over a valid/ready stream. Emits the full N-bit codeword (message beats, then N-K parity beats) on a registered valid/ready output stream.
- Supports back-pressure and back-to-back codewords with no idle bubbles.
- Sits between the framer and the modulator-side serialiser in the TX datapath.

Parameters:
- N, 15, codeword length in bits.
- K, 7, message length in bits. P = N-K parity bits.
- WIDTH, 1, bits per beat. K mod WIDTH = 0 and P mod WIDTH = 0 are required; elaboration fails otherwise.
- GEN_POLY, 9'h1D1, generator polynomial, P+1 bits. Bit i is the coefficient of x^i; bit P must be 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  message beat; MSB is the earliest, highest-degree bit.
- in_valid  in  1  in_data valid.
- in_last  in  1  sender marks final message beat.
- in_ready  out  1  encoder accepts a beat this cycle.
- out_data  out  WIDTH  codeword beat; MSB is the earliest bit.
- out_valid  out  1  out_data valid.
- out_last  out  1  final parity beat of the codeword.
- out_ready  in  1  sink accepts out_data.
- err  out  1  one-cycle in_last mismatch pulse.

Behaviour:
- Reset: rst=1 at a clock edge clears everything, mid-codeword included. out_valid=0, out_last=0, out_data=0, err=0, LFSR=0, beat counter=0, state=DATA. The partial codeword is discarded.
- Output stage: a single register. adv = !out_valid || out_ready. The register loads only when adv=1. If adv=1 and nothing is loaded, out_valid goes to 0.
- State DATA:
  - in_ready = adv.
  - Accept = in_valid && in_ready. On accept: out_data <= in_data, out_valid <= 1, out_last <= 0.
  - LFSR update on accept, bit-serial unrolled WIDTH times, MSB first. fb = d ^ lfsr[P-1]; lfsr = (lfsr<<1) ^ (fb ? GEN_POLY[P-1:0] : 0).
  - Beat counter increments on accept. On accepting beat K/WIDTH-1: counter clears, go to PARITY.
- State PARITY:
  - in_ready = 0.
  - When adv=1: out_data <= lfsr[P-1 -: WIDTH], lfsr <= lfsr << WIDTH (zero fill), out_valid <= 1.
  - On the last parity beat (count P/WIDTH-1): out_last <= 1, counter clears, go to DATA. The LFSR is now zero, so no separate clear is needed.
- Latency: first input beat appears on out_data 1 cycle after acceptance.
- Throughput: with out_ready held high, exactly N/WIDTH cycles per codeword. The next codeword's first beat is accepted in the cycle after the last parity beat loads.
- Back-pressure: while out_valid && !out_ready, out_data, out_valid and out_last hold stable, and in_ready=0.
- Input: in_valid without in_ready is ignored, and nothing in the encoder changes.

Optional Feature:
- Macro BCH_LAST_CHECK_EN.
- Defined:
  - On every accepted beat, err <= in_last XOR (beat is final message beat). Otherwise err <= 0.
  - Framing is always by count; in_last never shortens or extends a codeword.
- Undefined: in_last is ignored and err is tied to 0.

Test Plan:
- Default params, beats 1,0,0,0,0,0,0, out_ready=1 -> out stream 1000000 then parity 11101000 (0xE8). out_last on beat 15. Output lags input by 1 cycle.
- Default params, message 1111111 -> parity 11111111. Message 0000001 -> codeword 000000111010001 (= g).
- N=15, K=5, WIDTH=5, GEN_POLY=11'h537, beat 5'b00001 -> out beats 00001, 01001, 10111. out_last on the third beat.
- Two codewords back-to-back with in_valid=1 and out_ready=1 -> 30 consecutive out_valid cycles. in_ready=0 only during the 8 parity-load cycles of each codeword.
- out_ready toggled 1,0,0,1 pseudo-randomly -> out_data and out_last stable while stalled. Codeword matches the first scenario.
- rst pulsed after 3 message beats, then the first-scenario message is sent -> output matches the first scenario exactly.
- With BCH_LAST_CHECK_EN, in_last on beat 4 of 7 -> err=1 for one cycle. Codeword is still 15 beats.

Source files
------------

// File: rtl/bch_encode_stream.sv
// Systematic binary BCH encoder: streams a K-bit message in WIDTH-bit beats, then appends N-K parity beats.
// Optional in_last framing check is compiled in with `define BCH_LAST_CHECK_EN.
module bch_encode_stream #(
    parameter int N                = 15,
    parameter int K                = 7,
    parameter int WIDTH            = 1,
    parameter logic [N-K:0] GEN_POLY = 9'h1D1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             err
);

    localparam int P         = N - K;
    localparam int MSG_BEATS = K / WIDTH;
    localparam int PAR_BEATS = P / WIDTH;
    localparam int MAX_BEATS = (MSG_BEATS > PAR_BEATS) ? MSG_BEATS : PAR_BEATS;
    localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BEATS - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_BEATS - 1);

    generate
        if ((P < 1) || ((K % WIDTH) != 0) || ((P % WIDTH) != 0) || (GEN_POLY[P] != 1'b1)) begin : g_param_check
            $error("bch_encode_stream: K and N-K must be multiples of WIDTH and GEN_POLY[N-K] must be 1");
        end
    endgenerate

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [P-1:0]     lfsr_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             out_last_reg;

    logic             adv;
    logic             accept;
    logic [P-1:0]     lfsr_next;

    // One serial division step per message bit, earliest (MSB) bit first.
    logic [P-1:0] lfsr_chain [WIDTH+1];
    assign lfsr_chain[0] = lfsr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lfsr_step
            logic fb;
            assign fb                = in_data[WIDTH-1-gi] ^ lfsr_chain[gi][P-1];
            assign lfsr_chain[gi+1]  = (lfsr_chain[gi] << 1) ^ (fb ? GEN_POLY[P-1:0] : '0);
        end
    endgenerate

    assign lfsr_next = lfsr_chain[WIDTH];
    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg == ST_DATA) && adv;
    assign accept    = in_valid && in_ready;

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_DATA;
            cnt_reg       <= '0;
            lfsr_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            case (state_reg)
                ST_DATA: begin
                    if (in_valid) begin
                        out_data_reg  <= in_data;
                        out_valid_reg <= 1'b1;
                        lfsr_reg      <= lfsr_next;
                        if (cnt_reg == MSG_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= ST_PARITY;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    // Shifting parity out leaves the LFSR at zero for the next codeword.
                    out_data_reg  <= lfsr_reg[P-1 -: WIDTH];
                    out_valid_reg <= 1'b1;
                    lfsr_reg      <= lfsr_reg << WIDTH;
                    if (cnt_reg == PAR_LAST) begin
                        out_last_reg <= 1'b1;
                        cnt_reg      <= '0;
                        state_reg    <= ST_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_DATA;
            endcase
        end
    end

`ifdef BCH_LAST_CHECK_EN
    logic err_reg;
    assign err = err_reg;

    // Framing is by count only; in_last just reports disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept ? (in_last ^ (cnt_reg == MSG_LAST)) : 1'b0;
        end
    end
`else
    logic unused_in_last;
    logic unused_accept;
    assign unused_in_last = in_last;
    assign unused_accept  = accept;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_bch_encode_stream.sv
// Directed bench for bch_encode_stream: default (15,7) code at WIDTH=1 plus a (15,5) WIDTH=5 instance.
// Expected codewords are hand-computed remainders of m(x)*x^P modulo the generator.
module tb_bch_encode_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [0:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [0:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       err;

    logic [4:0] in_data5;
    logic       in_valid5;
    logic       in_last5;
    logic       in_ready5;
    logic [4:0] out_data5;
    logic       out_valid5;
    logic       out_last5;
    logic       err5;

    bch_encode_stream dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err(err)
    );

    bch_encode_stream #(.N(15), .K(5), .WIDTH(5), .GEN_POLY(11'h537)) dut5 (
        .clk(clk), .rst(rst),
        .in_data(in_data5), .in_valid(in_valid5), .in_last(in_last5), .in_ready(in_ready5),
        .out_data(out_data5), .out_valid(out_valid5), .out_last(out_last5), .out_ready(1'b1),
        .err(err5)
    );

    int   chk_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic stall_mode = 1'b0;
    logic [3:0] ready_pat = 4'b1001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sink: out_ready follows a 1,0,0,1 pattern while stall_mode is set.
    initial begin : sink_drive
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? ready_pat[cyc[1:0]] : 1'b1;
        end
    end

    logic q_data[$];
    logic q_last[$];
    int   q_cyc[$];
    int   ir_low_cnt = 0;
    int   err_hi_cnt = 0;
    logic count_en = 1'b0;

    initial begin : monitor
        logic prev_stall;
        logic prev_data;
        logic prev_last;
        prev_stall = 1'b0;
        prev_data  = 1'b0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    chk("stall_valid", {31'b0, out_valid}, 32'd1);
                    chk("stall_data", {31'b0, out_data}, {31'b0, prev_data});
                    chk("stall_last", {31'b0, out_last}, {31'b0, prev_last});
                end
                if (out_valid && !out_ready) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                if (out_valid && out_ready) begin
                    q_data.push_back(out_data[0]);
                    q_last.push_back(out_last);
                    q_cyc.push_back(cyc);
                    $display("beat %0d: cyc=%0d data=%b last=%b err=%b", q_data.size() - 1, cyc, out_data, out_last, err);
                end
                if (count_en && !in_ready) ir_low_cnt++;
                if (err) err_hi_cnt++;
            end
            prev_stall = !rst && out_valid && !out_ready;
            prev_data  = out_data[0];
            prev_last  = out_last;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    // Sends the first nbeats bits of msg (MSB first); last_mask bit marks in_last per beat.
    task automatic send_beats(input logic [6:0] msg, input logic [6:0] last_mask, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int t;
            in_data  = msg[6-i];
            in_last  = last_mask[6-i];
            in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 200);
            chk("accept_wait", {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            if (i == 0) acc_cyc = cyc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("out_count", q_data.size(), n);
    endtask

    task automatic check_cw(input string tag, input int base, input logic [14:0] exp_cw);
        logic [14:0] obs_cw;
        logic [14:0] obs_last;
        obs_cw   = 'x;
        obs_last = 'x;
        for (int i = 0; i < 15; i++) begin
            if (base + i < q_data.size()) begin
                obs_cw[14-i]   = q_data[base+i];
                obs_last[14-i] = q_last[base+i];
            end
        end
        $display("codeword %s: %b last=%b", tag, obs_cw, obs_last);
        chk({tag, "_data"}, {17'b0, obs_cw}, {17'b0, exp_cw});
        chk({tag, "_last"}, {17'b0, obs_last}, 32'h1);
    endtask

    localparam logic [14:0] CW_IMPULSE = 15'b1000000_11101000;
    localparam logic [14:0] CW_ONES    = 15'b1111111_11111111;
    localparam logic [14:0] CW_G       = 15'b0000001_11010001;

    initial begin : stimulus
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_valid5 = 1'b0;
        in_data5  = '0;
        in_last5  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_out_data", {31'b0, out_data}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid5", {31'b0, out_valid5}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // WIDTH=5 (15,5) code: message 00001 -> 00001, 01001, 10111
        in_valid5 = 1'b1;
        in_data5  = 5'b00001;
        in_last5  = 1'b1;
        @(negedge clk);
        chk("w5_in_ready", {31'b0, in_ready5}, 32'd1);
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        in_last5  = 1'b0;
        @(negedge clk);
        chk("w5_beat0", {26'b0, out_valid5, out_data5}, {26'b0, 1'b1, 5'b00001});
        chk("w5_last0", {31'b0, out_last5}, 32'd0);
        @(negedge clk);
        chk("w5_beat1", {26'b0, out_valid5, out_data5}, {26'b0, 1'b1, 5'b01001});
        chk("w5_last1", {31'b0, out_last5}, 32'd0);
        @(negedge clk);
        chk("w5_beat2", {26'b0, out_valid5, out_data5}, {26'b0, 1'b1, 5'b10111});
        chk("w5_last2", {31'b0, out_last5}, 32'd1);
        @(negedge clk);
        chk("w5_idle", {31'b0, out_valid5}, 32'd0);
        @(posedge clk);
        #1;

        // Impulse message, sink always ready
        clear_q();
        send_beats(7'b1000000, 7'b0000001, 7);
        wait_out(15);
        check_cw("cw_impulse", 0, CW_IMPULSE);
        chk("latency", q_cyc[0], acc_cyc);
        chk("impulse_span", q_cyc[14] - q_cyc[0], 14);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back codewords: all-ones then 0000001
        clear_q();
        ir_low_cnt = 0;
        count_en   = 1'b1;
        send_beats(7'b1111111, 7'b0000001, 7);
        send_beats(7'b0000001, 7'b0000001, 7);
        wait_out(30);
        count_en = 1'b0;
        check_cw("cw_ones", 0, CW_ONES);
        check_cw("cw_g", 15, CW_G);
        chk("b2b_span", q_cyc[29] - q_cyc[0], 29);
        chk("b2b_in_ready_low", ir_low_cnt, 16);
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure with out_ready pattern 1,0,0,1
        clear_q();
        stall_mode = 1'b1;
        send_beats(7'b1000000, 7'b0000001, 7);
        wait_out(15);
        stall_mode = 1'b0;
        check_cw("cw_stall", 0, CW_IMPULSE);
        chk("stall_span_stretched", {31'b0, (q_cyc[14] - q_cyc[0]) > 14}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Reset after three message beats discards the partial codeword
        send_beats(7'b1100000, 7'b0000000, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        clear_q();
        send_beats(7'b1000000, 7'b0000001, 7);
        wait_out(15);
        check_cw("cw_after_rst", 0, CW_IMPULSE);
        repeat (2) @(posedge clk);
        #1;

        // in_last asserted early on beat 4 (and correctly on beat 7): count framing holds
        chk("err_quiet", err_hi_cnt, 0);
        clear_q();
        err_hi_cnt = 0;
        send_beats(7'b1000000, 7'b0001001, 7);
        wait_out(15);
        check_cw("cw_early_last", 0, CW_IMPULSE);
`ifdef BCH_LAST_CHECK_EN
        chk("err_pulses", err_hi_cnt, 1);
`else
        chk("err_pulses", err_hi_cnt, 0);
`endif
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
